// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded operands and control from ID for EX,
// with debug freeze (i_enable), flush/bubble NOP insertion; optional ID_EX_BUBBLE_CNT_EN counter.
module id_ex_reg #(
  parameter int DATA_SIZE      = 32,
  parameter int REG_ADDR_SIZE  = 5,
  parameter int FUNC_CODE_SIZE = 6,
  parameter int OPCODE_SIZE    = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_enable,
  input  logic                      i_flush,
  input  logic                      i_bubble,
  input  logic [DATA_SIZE-1:0]      i_pc_plus4,
  input  logic [DATA_SIZE-1:0]      i_data_a,
  input  logic [DATA_SIZE-1:0]      i_data_b,
  input  logic [DATA_SIZE-1:0]      i_immediate,
  input  logic [REG_ADDR_SIZE-1:0]  i_rs,
  input  logic [REG_ADDR_SIZE-1:0]  i_rt,
  input  logic [REG_ADDR_SIZE-1:0]  i_rd,
  input  logic [REG_ADDR_SIZE-1:0]  i_shamt,
  input  logic [FUNC_CODE_SIZE-1:0] i_funct_code,
  input  logic [OPCODE_SIZE-1:0]    i_opcode,
  input  logic                      i_reg_write,
  input  logic                      i_mem_read,
  input  logic                      i_mem_write,
  input  logic                      i_mem_to_reg,
  input  logic                      i_reg_dst,
  input  logic                      i_alu_src,
  input  logic                      i_halt,
  input  logic [1:0]                i_word_size,
  input  logic                      i_unsigned,
  output logic [DATA_SIZE-1:0]      o_pc_plus4,
  output logic [DATA_SIZE-1:0]      o_data_a,
  output logic [DATA_SIZE-1:0]      o_data_b,
  output logic [DATA_SIZE-1:0]      o_immediate,
  output logic [REG_ADDR_SIZE-1:0]  o_rs,
  output logic [REG_ADDR_SIZE-1:0]  o_rt,
  output logic [REG_ADDR_SIZE-1:0]  o_rd,
  output logic [REG_ADDR_SIZE-1:0]  o_shamt,
  output logic [FUNC_CODE_SIZE-1:0] o_funct_code,
  output logic [OPCODE_SIZE-1:0]    o_opcode,
  output logic                      o_reg_write,
  output logic                      o_mem_read,
  output logic                      o_mem_write,
  output logic                      o_mem_to_reg,
  output logic                      o_reg_dst,
  output logic                      o_alu_src,
  output logic                      o_halt,
  output logic [1:0]                o_word_size,
  output logic                      o_unsigned,
  output logic                      o_valid
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0]               o_bubble_count
`endif
);

  typedef struct packed {
    logic [DATA_SIZE-1:0]      pc_plus4;
    logic [DATA_SIZE-1:0]      data_a;
    logic [DATA_SIZE-1:0]      data_b;
    logic [DATA_SIZE-1:0]      immediate;
    logic [REG_ADDR_SIZE-1:0]  rs;
    logic [REG_ADDR_SIZE-1:0]  rt;
    logic [REG_ADDR_SIZE-1:0]  rd;
    logic [REG_ADDR_SIZE-1:0]  shamt;
    logic [FUNC_CODE_SIZE-1:0] funct_code;
    logic [OPCODE_SIZE-1:0]    opcode;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      mem_to_reg;
    logic                      reg_dst;
    logic                      alu_src;
    logic                      halt;
    logic [1:0]                word_size;
    logic                      unsigned_ld;
  } stage_t;

  stage_t stage_q, stage_d, stage_in;
  logic   valid_q, valid_d;
  logic   insert_nop;

  // A bubble is an all-zero stage word: opcode/funct 0 decode as SLL $0,$0,0.
  assign insert_nop = i_flush | i_bubble;

  always_comb begin
    stage_in.pc_plus4    = i_pc_plus4;
    stage_in.data_a      = i_data_a;
    stage_in.data_b      = i_data_b;
    stage_in.immediate   = i_immediate;
    stage_in.rs          = i_rs;
    stage_in.rt          = i_rt;
    stage_in.rd          = i_rd;
    stage_in.shamt       = i_shamt;
    stage_in.funct_code  = i_funct_code;
    stage_in.opcode      = i_opcode;
    stage_in.reg_write   = i_reg_write;
    stage_in.mem_read    = i_mem_read;
    stage_in.mem_write   = i_mem_write;
    stage_in.mem_to_reg  = i_mem_to_reg;
    stage_in.reg_dst     = i_reg_dst;
    stage_in.alu_src     = i_alu_src;
    stage_in.halt        = i_halt;
    stage_in.word_size   = i_word_size;
    stage_in.unsigned_ld = i_unsigned;
  end

  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    if (i_enable) begin
      if (insert_nop) begin
        stage_d = '0;
        valid_d = 1'b0;
      end else begin
        stage_d = stage_in;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_q <= '0;
      valid_q <= 1'b0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating count of NOPs inserted on enabled edges; flush+bubble counts once.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (i_enable && insert_nop && (bubble_cnt_q != 16'hFFFF))
      bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) bubble_cnt_q <= '0;
    else          bubble_cnt_q <= bubble_cnt_d;
  end

  assign o_bubble_count = bubble_cnt_q;
`endif

  assign o_pc_plus4   = stage_q.pc_plus4;
  assign o_data_a     = stage_q.data_a;
  assign o_data_b     = stage_q.data_b;
  assign o_immediate  = stage_q.immediate;
  assign o_rs         = stage_q.rs;
  assign o_rt         = stage_q.rt;
  assign o_rd         = stage_q.rd;
  assign o_shamt      = stage_q.shamt;
  assign o_funct_code = stage_q.funct_code;
  assign o_opcode     = stage_q.opcode;
  assign o_reg_write  = stage_q.reg_write;
  assign o_mem_read   = stage_q.mem_read;
  assign o_mem_write  = stage_q.mem_write;
  assign o_mem_to_reg = stage_q.mem_to_reg;
  assign o_reg_dst    = stage_q.reg_dst;
  assign o_alu_src    = stage_q.alu_src;
  assign o_halt       = stage_q.halt;
  assign o_word_size  = stage_q.word_size;
  assign o_unsigned   = stage_q.unsigned_ld;
  assign o_valid      = valid_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, load, bubble, freeze, flush, halt and optional counter.
module tb_id_ex_reg;

  typedef struct packed {
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct, op;
    logic        rw, mr, mw, m2r, rdst, asrc, halt;
    logic [1:0]  ws;
    logic        uns;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1, flush = 1'b0, bubble = 1'b0;
  vec_t        vin = '0;
  vec_t        vout;
  logic        valid;
  int          checks = 0, passed = 0;
  vec_t        v_addu, v_addi, v_lw, v_a, v_c, v_halt, v_next;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bcount;
  logic [15:0] exp_cnt = 16'd0;
`endif

  always #5 clk = ~clk;

  id_ex_reg dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_flush(flush), .i_bubble(bubble),
    .i_pc_plus4(vin.pc), .i_data_a(vin.a), .i_data_b(vin.b), .i_immediate(vin.imm),
    .i_rs(vin.rs), .i_rt(vin.rt), .i_rd(vin.rd), .i_shamt(vin.shamt),
    .i_funct_code(vin.funct), .i_opcode(vin.op),
    .i_reg_write(vin.rw), .i_mem_read(vin.mr), .i_mem_write(vin.mw),
    .i_mem_to_reg(vin.m2r), .i_reg_dst(vin.rdst), .i_alu_src(vin.asrc),
    .i_halt(vin.halt), .i_word_size(vin.ws), .i_unsigned(vin.uns),
    .o_pc_plus4(vout.pc), .o_data_a(vout.a), .o_data_b(vout.b), .o_immediate(vout.imm),
    .o_rs(vout.rs), .o_rt(vout.rt), .o_rd(vout.rd), .o_shamt(vout.shamt),
    .o_funct_code(vout.funct), .o_opcode(vout.op),
    .o_reg_write(vout.rw), .o_mem_read(vout.mr), .o_mem_write(vout.mw),
    .o_mem_to_reg(vout.m2r), .o_reg_dst(vout.rdst), .o_alu_src(vout.asrc),
    .o_halt(vout.halt), .o_word_size(vout.ws), .o_unsigned(vout.uns),
    .o_valid(valid)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .o_bubble_count(bcount)
`endif
  );

  task automatic check(input string tag, input vec_t exp_v, input logic exp_valid);
    checks++;
    assert (vout === exp_v) passed++;
    else $error("FAIL %s fields: got %h want %h", tag, vout, exp_v);
    checks++;
    assert (valid === exp_valid) passed++;
    else $error("FAIL %s valid: got %b want %b", tag, valid, exp_valid);
  endtask

`ifdef ID_EX_BUBBLE_CNT_EN
  task automatic check_cnt(input string tag);
    checks++;
    assert (bcount === exp_cnt) passed++;
    else $error("FAIL %s count: got %h want %h", tag, bcount, exp_cnt);
  endtask
`endif

  // Inputs change on the falling edge; outputs are checked on the falling edge after.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    v_addu = '{pc:32'h0000_0104, a:32'h10, b:32'h20, imm:32'h0000_1821, rs:5'd1, rt:5'd2,
               rd:5'd3, shamt:5'd0, funct:6'h21, op:6'h00, rw:1'b1, mr:1'b0, mw:1'b0,
               m2r:1'b0, rdst:1'b1, asrc:1'b0, halt:1'b0, ws:2'b11, uns:1'b0};
    v_addi = '{pc:32'h0000_0108, a:32'h7, b:32'h0, imm:32'h5, rs:5'd4, rt:5'd5,
               rd:5'd0, shamt:5'd0, funct:6'h05, op:6'h08, rw:1'b1, mr:1'b0, mw:1'b0,
               m2r:1'b0, rdst:1'b0, asrc:1'b1, halt:1'b0, ws:2'b11, uns:1'b0};
    v_lw   = '{pc:32'h0000_010C, a:32'h1000, b:32'hDEAD_BEEF, imm:32'hFFFF_FFFC, rs:5'd6,
               rt:5'd7, rd:5'd31, shamt:5'd31, funct:6'h3C, op:6'h23, rw:1'b1, mr:1'b1,
               mw:1'b0, m2r:1'b1, rdst:1'b0, asrc:1'b1, halt:1'b0, ws:2'b11, uns:1'b0};
    v_a    = '{pc:32'hA5A5_A5A5, a:32'h1111_1111, b:32'h2222_2222, imm:32'h3333_3333,
               rs:5'd10, rt:5'd11, rd:5'd12, shamt:5'd13, funct:6'h2A, op:6'h2B, rw:1'b0,
               mr:1'b0, mw:1'b1, m2r:1'b0, rdst:1'b0, asrc:1'b1, halt:1'b0, ws:2'b01,
               uns:1'b1};
    v_c    = '{pc:32'h5A5A_5A5A, a:32'hCAFE_0000, b:32'h0000_F00D, imm:32'h0000_0080,
               rs:5'd21, rt:5'd22, rd:5'd23, shamt:5'd24, funct:6'h15, op:6'h24, rw:1'b1,
               mr:1'b1, mw:1'b0, m2r:1'b1, rdst:1'b0, asrc:1'b1, halt:1'b0, ws:2'b00,
               uns:1'b1};
    v_halt = '{pc:32'h0000_0200, a:32'h0, b:32'h0, imm:32'h0, rs:5'd0, rt:5'd0, rd:5'd0,
               shamt:5'd0, funct:6'h00, op:6'h3F, rw:1'b0, mr:1'b0, mw:1'b0, m2r:1'b0,
               rdst:1'b0, asrc:1'b0, halt:1'b1, ws:2'b00, uns:1'b0};
    v_next = '{pc:32'h0000_0204, a:32'h9, b:32'h8, imm:32'h7, rs:5'd3, rt:5'd2, rd:5'd1,
               shamt:5'd4, funct:6'h20, op:6'h00, rw:1'b1, mr:1'b0, mw:1'b0, m2r:1'b0,
               rdst:1'b1, asrc:1'b0, halt:1'b0, ws:2'b11, uns:1'b0};

    // Reset state
    #1;
    check("reset", '0, 1'b0);
`ifdef ID_EX_BUBBLE_CNT_EN
    check_cnt("reset");
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-run async reset after loading ADDI
    vin = v_addi;
    tick();
    check("load_addi", v_addi, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain load of ADDU
    vin = v_addu;
    tick();
    check("load_addu", v_addu, 1'b1);

    // Load-use bubble on LW, then LW loads
    vin = v_lw;
    bubble = 1'b1;
    tick();
    check("bubble", '0, 1'b0);
`ifdef ID_EX_BUBBLE_CNT_EN
    exp_cnt++;
    check_cnt("bubble");
`endif
    bubble = 1'b0;
    tick();
    check("lw_after_bubble", v_lw, 1'b1);

    // Freeze for three cycles with flush asserted and inputs changing
    vin = v_a;
    tick();
    check("load_a", v_a, 1'b1);
    enable = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vin = (i % 2 == 0) ? v_lw : v_addu;
      tick();
      check($sformatf("freeze%0d", i), v_a, 1'b1);
`ifdef ID_EX_BUBBLE_CNT_EN
      check_cnt($sformatf("freeze%0d", i));
`endif
    end
    enable = 1'b1;
    flush = 1'b0;
    vin = v_c;
    tick();
    check("unfreeze_load", v_c, 1'b1);

    // Flush alone
    vin = v_addu;
    flush = 1'b1;
    tick();
    check("flush", '0, 1'b0);
`ifdef ID_EX_BUBBLE_CNT_EN
    exp_cnt++;
    check_cnt("flush");
`endif

    // Freeze while a bubble is held keeps valid low
    flush = 1'b0;
    enable = 1'b0;
    tick();
    check("freeze_bubble", '0, 1'b0);
    enable = 1'b1;

    // Flush and bubble together make one NOP
    vin = v_c;
    flush = 1'b1;
    bubble = 1'b1;
    tick();
    check("flush_bubble", '0, 1'b0);
`ifdef ID_EX_BUBBLE_CNT_EN
    exp_cnt++;
    check_cnt("flush_bubble");
`endif
    flush = 1'b0;
    bubble = 1'b0;

    // Halt is latched and the register keeps loading afterwards
    vin = v_halt;
    tick();
    check("halt_load", v_halt, 1'b1);
    vin = v_next;
    tick();
    check("after_halt", v_next, 1'b1);

`ifdef ID_EX_BUBBLE_CNT_EN
    // Saturation of the bubble counter
    force dut.bubble_cnt_q = 16'hFFFE;
    #1 release dut.bubble_cnt_q;
    bubble = 1'b1;
    exp_cnt = 16'hFFFF;
    tick();
    check_cnt("sat1");
    tick();
    check_cnt("sat2");
    enable = 1'b0;
    tick();
    check_cnt("sat_frozen");
    enable = 1'b1;
    bubble = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
